// File: rtl/upsize_pack_pkg.sv
// Shared constants and helpers for the upsize_pack sample-to-wide-word packer.
// Defaults describe the reference 4-lane, 20->32 bit, shift-by-12 configuration.
package upsize_pack_pkg;

  localparam int DEF_PARALLEL_OUT = 4;
  localparam int DEF_DIN_WIDTH    = 20;
  localparam int DEF_DOUT_WIDTH   = 32;
  localparam int DEF_SHIFT        = 12;

  // Sign-extension pad for the default configuration.
  localparam int LANE_PAD = DEF_DOUT_WIDTH - DEF_DIN_WIDTH;

  // Lane counter width; a single-lane build still needs one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Low bit index of lane 'lane' inside a packed word of 'width'-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/upsize_lane.sv
// Widens one signed narrow sample into a wide lane: sign-extend, then shift left
// so the fractional point lines up with the wide format.
module upsize_lane #(
  parameter int DIN_WIDTH  = 20,
  parameter int DOUT_WIDTH = 32,
  parameter int SHIFT      = 12
) (
  input  logic [DIN_WIDTH-1:0]  din,
  output logic [DOUT_WIDTH-1:0] lane
);

  logic signed [DOUT_WIDTH-1:0] ext;

  assign ext  = DOUT_WIDTH'($signed(din));
  assign lane = ext <<< SHIFT;

endmodule

// File: rtl/upsize_pack.sv
// Packs PARALLEL_OUT widened samples into one output word with a double buffer.
// Optional flush (din_last / dout_keep) is enabled by defining UPSIZE_PACK_FLUSH_EN.
module upsize_pack
  import upsize_pack_pkg::*;
#(
  parameter int PARALLEL_OUT = DEF_PARALLEL_OUT,
  parameter int DIN_WIDTH    = DEF_DIN_WIDTH,
  parameter int DOUT_WIDTH   = DEF_DOUT_WIDTH,
  parameter int SHIFT        = DEF_SHIFT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DIN_WIDTH-1:0]             din,
  input  logic                             din_valid,
  output logic                             din_ready,
`ifdef UPSIZE_PACK_FLUSH_EN
  input  logic                             din_last,
  output logic [PARALLEL_OUT-1:0]          dout_keep,
`endif
  output logic [PARALLEL_OUT*DOUT_WIDTH-1:0] dout,
  output logic                             dout_valid,
  input  logic                             dout_ready
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and dout holds steady while unaccepted.

  localparam int             CW   = cnt_width(PARALLEL_OUT);
  localparam int             WW   = PARALLEL_OUT * DOUT_WIDTH;
  localparam logic [CW-1:0]  LAST = CW'(PARALLEL_OUT - 1);

  if (DIN_WIDTH + SHIFT > DOUT_WIDTH) begin : g_bad_cfg
    $error("upsize_pack: DIN_WIDTH+SHIFT must not exceed DOUT_WIDTH");
  end

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WW-1:0]  collect_q, collect_d;
  logic [WW-1:0]  dout_q, dout_d;
  logic           dout_valid_q, dout_valid_d;
  logic [DOUT_WIDTH-1:0] lane_w;
  logic [WW-1:0]  word_w;
  logic           last_in, at_last, accept, complete, din_ready_w;

`ifdef UPSIZE_PACK_FLUSH_EN
  logic [PARALLEL_OUT-1:0] keep_q, keep_d, keep_w;
  assign last_in   = din_last;
  assign dout_keep = keep_q;
`else
  assign last_in   = 1'b0;
`endif

  upsize_lane #(
    .DIN_WIDTH (DIN_WIDTH),
    .DOUT_WIDTH(DOUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_lane (
    .din (din),
    .lane(lane_w)
  );

  always_comb begin
    at_last      = (cnt_q == LAST) || last_in;
    // Only the word-completing sample must wait for the output buffer to drain.
    din_ready_w  = !(at_last && dout_valid_q && !dout_ready);
    accept       = din_valid && din_ready_w;
    complete     = accept && at_last;

    word_w = collect_q;
    for (int i = 0; i < PARALLEL_OUT; i++) begin
      if (cnt_q == CW'(i)) word_w[lane_lsb(i, DOUT_WIDTH) +: DOUT_WIDTH] = lane_w;
    end

    cnt_d        = cnt_q;
    collect_d    = collect_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;

    if (accept) begin
      if (complete) begin
        // Clearing the collector keeps unfilled lanes of a flushed word at zero.
        cnt_d        = '0;
        collect_d    = '0;
        dout_d       = word_w;
        dout_valid_d = 1'b1;
      end else begin
        cnt_d     = cnt_q + CW'(1);
        collect_d = word_w;
      end
    end
  end

`ifdef UPSIZE_PACK_FLUSH_EN
  always_comb begin
    keep_w = '0;
    for (int i = 0; i < PARALLEL_OUT; i++) begin
      keep_w[i] = (CW'(i) <= cnt_q);
    end
    keep_d = complete ? keep_w : keep_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) keep_q <= '0;
    else        keep_q <= keep_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      collect_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      collect_q    <= collect_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign din_ready  = din_ready_w;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_upsize_pack.sv
// Directed and randomised checks for upsize_pack in its default 4 x 20->32, shift 12 form.
module tb_upsize_pack;

  localparam int P  = 4;
  localparam int DW = 20;
  localparam int OW = 32;
  localparam int WW = P * OW;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [WW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
`ifdef UPSIZE_PACK_FLUSH_EN
  logic          din_last;
  logic [P-1:0]  dout_keep;
`endif

  int n_checks;
  int n_pass;
  logic [WW-1:0] exp_q[$];

  upsize_pack u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
`ifdef UPSIZE_PACK_FLUSH_EN
    .din_last  (din_last),
    .dout_keep (dout_keep),
`endif
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference widening: the sample's signed value times 2^12, kept to 32 bits.
  function automatic logic [OW-1:0] model_lane(input logic [DW-1:0] d);
    logic signed [DW-1:0] s;
    int v;
    s = d;
    v = s;
    return OW'(v * 4096);
  endfunction

  function automatic logic [WW-1:0] pack4(input logic [DW-1:0] a, b, c, d);
    return {model_lane(d), model_lane(c), model_lane(b), model_lane(a)};
  endfunction

  // ---------------- drivers ----------------
  // Holds one sample on din until it is accepted (bounded), then deasserts valid.
  task automatic send(input logic [DW-1:0] d, input logic last);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    din = d;
    din_valid = 1'b1;
`ifdef UPSIZE_PACK_FLUSH_EN
    din_last = last;
`endif
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = din_ready;
      @(posedge clk); #1;
      n++;
    end
    din_valid = 1'b0;
`ifdef UPSIZE_PACK_FLUSH_EN
    din_last = 1'b0;
`endif
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: din_ready=%0b after %0d cycles, required 1", din_ready, n);
    end else if (last) begin
      n = 0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
`ifdef UPSIZE_PACK_FLUSH_EN
    din_last = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dout !== '0 || dout_valid !== 1'b0 || din_ready !== 1'b1)
      $display("FAIL reset_state: dout=%h dout_valid=%b din_ready=%b, required 0/0/1", dout, dout_valid, din_ready);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [WW-1:0] exp;
    exp = {32'h80000000, 32'h7FFFF000, 32'hFFFFF000, 32'h00001000};
    dout_ready = 1'b1;
    send(20'h00001, 1'b0);
    send(20'hFFFFF, 1'b0);
    send(20'h7FFFF, 1'b0);
    n_checks++;
    if (dout_valid !== 1'b0) $display("FAIL basic_early_valid: dout_valid=%b, required 0", dout_valid);
    else n_pass++;
    send(20'h80000, 1'b0);
    n_checks++;
    if (dout_valid !== 1'b1 || dout !== exp)
      $display("FAIL basic_word: dout_valid=%b dout=%h, required 1 %h", dout_valid, dout, exp);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (dout_valid !== 1'b0) $display("FAIL basic_drop: dout_valid=%b, required 0", dout_valid);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [DW-1:0] s[12];
    logic [WW-1:0] exp;
    int ready_drops;
    int pulses;
    ready_drops = 0;
    pulses = 0;
    for (int i = 0; i < 12; i++) s[i] = DW'(i * 40503 - 250000);
    dout_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      din = s[i];
      din_valid = 1'b1;
      @(negedge clk);
      if (din_ready !== 1'b1) ready_drops++;
      @(posedge clk); #1;
      if (dout_valid === 1'b1) pulses++;
      if (i % 4 == 3) begin
        exp = pack4(s[i-3], s[i-2], s[i-1], s[i]);
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== exp)
          $display("FAIL stream_word%0d: dout_valid=%b dout=%h, required 1 %h", i / 4, dout_valid, dout, exp);
        else n_pass++;
      end
    end
    din_valid = 1'b0;
    @(posedge clk); #1;
    if (dout_valid === 1'b1) pulses++;
    n_checks++;
    if (ready_drops != 0) $display("FAIL stream_din_ready: drops=%0d, required 0", ready_drops);
    else n_pass++;
    n_checks++;
    if (pulses != 3) $display("FAIL stream_pulses: pulses=%0d, required 3", pulses);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [WW-1:0] wa, wb;
    wa = pack4(20'h12345, 20'hABCDE, 20'h00F00, 20'hFF00F);
    wb = pack4(20'h11111, 20'hEEEEE, 20'h40000, 20'hC0001);
    dout_ready = 1'b0;
    send(20'h12345, 1'b0); send(20'hABCDE, 1'b0); send(20'h00F00, 1'b0); send(20'hFF00F, 1'b0);
    send(20'h11111, 1'b0); send(20'hEEEEE, 1'b0); send(20'h40000, 1'b0);
    n_checks++;
    if (din_ready !== 1'b0) $display("FAIL bp_stall: din_ready=%b, required 0", din_ready);
    else n_pass++;
    din = 20'hC0001;
    din_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (din_ready !== 1'b0 || dout_valid !== 1'b1 || dout !== wa)
        $display("FAIL bp_hold%0d: din_ready=%b dout_valid=%b dout=%h, required 0 1 %h", k, din_ready, dout_valid, dout, wa);
      else n_pass++;
    end
    dout_ready = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    n_checks++;
    if (dout_valid !== 1'b1 || dout !== wb)
      $display("FAIL bp_replace: dout_valid=%b dout=%h, required 1 %h", dout_valid, dout, wb);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (dout_valid !== 1'b0) $display("FAIL bp_drain: dout_valid=%b, required 0", dout_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [WW-1:0] part, got, held;
    int pcnt, sent, cyc, bad_hold, bad_ready;
    bit hold_pending, ready_exp;
    part = '0; pcnt = 0; sent = 0; cyc = 0; bad_hold = 0; bad_ready = 0;
    hold_pending = 1'b0; held = '0;
    exp_q.delete();
    while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      din_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      din        = DW'($urandom);
      dout_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (hold_pending && (dout_valid !== 1'b1 || dout !== held)) bad_hold++;
      hold_pending = dout_valid && !dout_ready;
      held = dout;
      ready_exp = !(pcnt == P - 1 && dout_valid && !dout_ready);
      if (din_ready !== ready_exp) bad_ready++;
      if (dout_valid && dout_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_extra_word: dout=%h with empty expected queue", dout);
        end else begin
          got = exp_q.pop_front();
          if (dout !== got) $display("FAIL rand_word: dout=%h, required %h", dout, got);
          else n_pass++;
        end
      end
      if (din_valid && din_ready) begin
        part[pcnt*OW +: OW] = model_lane(din);
        pcnt++;
        sent++;
        if (pcnt == P) begin
          exp_q.push_back(part);
          part = '0;
          pcnt = 0;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    din_valid = 1'b0;
    n_checks++;
    if (sent != 1000 || exp_q.size() != 0)
      $display("FAIL rand_complete: sent=%0d pending=%0d, required 1000 0", sent, exp_q.size());
    else n_pass++;
    n_checks++;
    if (bad_hold != 0) $display("FAIL rand_hold: unstable cycles=%0d, required 0", bad_hold);
    else n_pass++;
    n_checks++;
    if (bad_ready != 0) $display("FAIL rand_din_ready: wrong cycles=%0d, required 0", bad_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [WW-1:0] exp;
    exp = pack4(20'h00002, 20'hFFFFE, 20'h3FFFF, 20'hC0000);
    dout_ready = 1'b0;
    send(20'h55555, 1'b0); send(20'h66666, 1'b0); send(20'h77777, 1'b0); send(20'h88888, 1'b0);
    send(20'h99999, 1'b0); send(20'hAAAAA, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dout !== '0 || dout_valid !== 1'b0 || din_ready !== 1'b1)
      $display("FAIL reset_mid_outputs: dout=%h dout_valid=%b din_ready=%b, required 0/0/1", dout, dout_valid, din_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dout_ready = 1'b1;
    send(20'h00002, 1'b0); send(20'hFFFFE, 1'b0); send(20'h3FFFF, 1'b0); send(20'hC0000, 1'b0);
    n_checks++;
    if (dout_valid !== 1'b1 || dout !== exp)
      $display("FAIL reset_mid_word: dout_valid=%b dout=%h, required 1 %h", dout_valid, dout, exp);
    else n_pass++;
    @(posedge clk); #1;
  endtask

`ifdef UPSIZE_PACK_FLUSH_EN
  task automatic test_flush();
    logic [WW-1:0] exp;
    dout_ready = 1'b1;
    exp = {32'h0, 32'h0, 32'h00020000, 32'h00010000};
    send(20'h00010, 1'b0);
    send(20'h00020, 1'b1);
    n_checks++;
    if (dout_valid !== 1'b1 || dout !== exp || dout_keep !== 4'b0011)
      $display("FAIL flush_word: dout_valid=%b dout=%h keep=%b, required 1 %h 0011", dout_valid, dout, dout_keep, exp);
    else n_pass++;
    exp = {32'h0, 32'h0, 32'h0, 32'h00003000};
    send(20'h00003, 1'b1);
    n_checks++;
    if (dout_valid !== 1'b1 || dout !== exp || dout_keep !== 4'b0001)
      $display("FAIL flush_next_lane0: dout_valid=%b dout=%h keep=%b, required 1 %h 0001", dout_valid, dout, dout_keep, exp);
    else n_pass++;
    exp = pack4(20'h00001, 20'h00002, 20'h00003, 20'h00004);
    send(20'h00001, 1'b0); send(20'h00002, 1'b0); send(20'h00003, 1'b0); send(20'h00004, 1'b0);
    n_checks++;
    if (dout !== exp || dout_keep !== 4'b1111)
      $display("FAIL flush_full_keep: dout=%h keep=%b, required %h 1111", dout, dout_keep, exp);
    else n_pass++;
    @(posedge clk); #1;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef UPSIZE_PACK_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/upsize_pack.md
Name: upsize_pack

Overview:
- Inverse of the neuron's downsize stage: accepts a serial stream of narrow signed fixed-point samples and expands each one to a wide lane.
- Expansion: sign-extend to DOUT_WIDTH, then arithmetic left shift by SHIFT to realign the fractional point.
- Packs PARALLEL_OUT consecutive samples into one wide word for the parallel neuron/MAC input.
- Valid/ready handshake on both sides; double-buffered so it sustains one sample per cycle.

Parameters:
- PARALLEL_OUT, 4: lanes per output word.
- DIN_WIDTH, 20: input sample width, signed.
- DOUT_WIDTH, 32: output lane width, signed.
- SHIFT, 12: left shift applied after sign extension. Constraint: DIN_WIDTH+SHIFT <= DOUT_WIDTH, checked at elaboration.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  DIN_WIDTH  signed input sample.
- din_valid  in  1  din is valid this cycle.
- din_ready  out  1  block accepts din this cycle.
- dout  out  PARALLEL_OUT*DOUT_WIDTH  packed word. Lane i = dout[i*DOUT_WIDTH +: DOUT_WIDTH]. Lane 0 holds the first sample received.
- dout_valid  out  1  dout holds a complete word.
- dout_ready  in  1  downstream accepts dout.

Behaviour:
- Reset (async assert, sync release): dout=0, dout_valid=0, din_ready=1, lane counter cnt=0, collect register=0.
- Accept condition: a sample is accepted when din_valid && din_ready.
- Lane arithmetic: lane = ({{(DOUT_WIDTH-DIN_WIDTH){din[MSB]}}, din}) <<< SHIFT. The low SHIFT bits are zero. No overflow is possible.
- Collection: an accepted sample is written to collect lane cnt; cnt increments and wraps from PARALLEL_OUT-1 to 0.
- Transfer: when the sample filling lane PARALLEL_OUT-1 is accepted, the completed word (including that sample) loads into the output register on the same edge. dout_valid=1 on the next cycle.
- Latency: 1 cycle from acceptance of the last lane sample to dout_valid.
- Output hold: dout and dout_valid stay stable while dout_valid && !dout_ready. Drops after a handshake.
- din_ready = !(cnt==PARALLEL_OUT-1 && dout_valid && !dout_ready). Backpressure only stalls the final lane of the next word; lanes 0..PARALLEL_OUT-2 continue collecting.
- Simultaneous completion and dout handshake in the same cycle: the new word replaces the old one, dout_valid stays 1, and no bubble is inserted.
- dout handshake without a new completion: dout_valid goes to 0 next cycle. dout retains its last value (don't-care).
- din_valid=0: no state change, cnt holds.
- Reset mid-word: partial collection is discarded, cnt=0, and any pending dout is dropped.
- Sustained throughput: 1 sample/cycle with dout_ready=1. Output is one word every PARALLEL_OUT cycles.

Optional Feature:
- Macro: UPSIZE_PACK_FLUSH_EN.
- Defined: adds input din_last (1 bit, qualified by the din handshake) and output dout_keep (PARALLEL_OUT bits).
  - A sample accepted with din_last=1 completes the word immediately; unfilled higher lanes are zero.
  - dout_keep has bit i set for each filled lane; a full word gives all ones.
  - cnt returns to 0 after a din_last sample.
  - din_ready stall rule applies when cnt==PARALLEL_OUT-1 or din_last=1.
- Undefined: ports are absent and words complete only on a full count.

Decomposition:
- Package upsize_pack_pkg holds:
  - localparam LANE_PAD = DOUT_WIDTH-DIN_WIDTH;
  - the counter width function clog2(PARALLEL_OUT);
  - the lane slice helper function.
- Sub-module upsize_lane: combinational sign-extend plus shift of one sample, parameterised on DIN_WIDTH/DOUT_WIDTH/SHIFT. It is instantiated once, feeding the collect lane mux.

Test Plan (defaults: 4 lanes, 20->32, SHIFT=12):
1. Reset then inputs 0x00001, 0xFFFFF, 0x7FFFF, 0x80000 on back-to-back cycles with dout_ready=1 -> one cycle after the 4th, dout_valid=1 with lanes 0..3 = 0x00001000, 0xFFFFF000, 0x7FFFF000, 0x80000000.
2. Continuous 12 samples, dout_ready=1 -> 3 words, dout_valid pulses every 4 cycles, din_ready never drops.
3. Word 1 pending with dout_ready=0, feed 4 more -> din_ready=0 while waiting on the 4th sample. Word 1 stays stable. Raise dout_ready -> word 2 follows next cycle with no lost or duplicated samples.
4. Random din_valid/dout_ready toggling, 1000 samples -> scoreboard matches expected lane ordering and values.
5. Assert rst_n low after 2 samples of a word -> outputs 0 immediately. The next 4 samples form a clean word starting at lane 0.
6. With UPSIZE_PACK_FLUSH_EN: 2 samples, the second with din_last=1 -> dout_keep=4'b0011, lanes 2..3 = 0, and the next sample lands in lane 0.
